// File: rtl/rnn_host_master.sv
//============================================================================
// Module   : rnn_host_master
// Purpose  : Memory-mapped initiator for the rnn accelerator slave port.
//            Loads a stream of parameter words to consecutive accelerator
//            addresses, kicks the accelerator, polls status until done and
//            fetches the result word.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle command pulse (honoured only in IDLE)
//   dst_base[31:0]      first accelerator address for stream words
//   word_count[15:0]    number of stream words to load
//   busy                high from accepted start until return to IDLE
//   s_valid/s_ready     stream word handshake
//   s_data[31:0]        stream word
//   m_read/m_write      one-cycle strobes to the accelerator
//   m_addr[31:0]        word address
//   m_wdata[31:0]       write data
//   m_rdata[31:0]       read data, valid RD_LAT cycles after m_read
//   result[31:0]        last fetched result, held until the next fetch
//   result_valid        one-cycle pulse when result updates
//   error               sticky poll-timeout flag
// Build option
//   RNN_HOST_POLL_TIMEOUT_EN : bound polling to TIMEOUT attempts; without it
//                              polling is unbounded and error stays 0.
//============================================================================
`default_nettype none

module rnn_host_master #(
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_1000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_1004,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_1008,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dst_base,
  input  logic [15:0] word_count,
  output logic        busy,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_POLL  = 3'd3,
    S_PWAIT = 3'd4,
    S_GAP   = 3'd5,
    S_FETCH = 3'd6,
    S_FWAIT = 3'd7
  } state_t;

  state_t      state;
  logic [31:0] base_q;
  logic [15:0] count_q;
  logic [15:0] idx;
  logic [31:0] cnt;        // shared read-latency / poll-gap counter

`ifdef RNN_HOST_POLL_TIMEOUT_EN
  logic [31:0] poll_cnt;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  // Bus strobes are registered on the edge that enters the state owning the
  // transfer, so the strobe is visible for exactly the cycle spent in
  // KICK / POLL / FETCH. The one exception is the LOAD->KICK hand-off: the
  // final stream write occupies the cycle after the last handshake, so the
  // control write is launched one cycle later when idx reaches count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      idx          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      s_ready      <= 1'b0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
`ifdef RNN_HOST_POLL_TIMEOUT_EN
      poll_cnt     <= '0;
`endif
    end else begin
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      result_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= dst_base;
            count_q <= word_count;
            idx     <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
`ifdef RNN_HOST_POLL_TIMEOUT_EN
            poll_cnt <= '0;
`endif
            if (word_count == 16'd0) begin
              state   <= S_KICK;
              m_write <= 1'b1;
              m_addr  <= CTRL_ADDR;
              m_wdata <= 32'd1;
            end else begin
              state   <= S_LOAD;
              s_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (s_valid && s_ready) begin
            m_write <= 1'b1;
            m_addr  <= base_q + {16'd0, idx};
            m_wdata <= s_data;
            idx     <= idx + 16'd1;
            // idx < count_q here, so idx+1 cannot wrap
            if (idx + 16'd1 == count_q) begin
              s_ready <= 1'b0;
            end
          end else if (idx == count_q) begin
            state   <= S_KICK;
            m_write <= 1'b1;
            m_addr  <= CTRL_ADDR;
            m_wdata <= 32'd1;
          end
        end

        S_KICK: begin
          state  <= S_POLL;
          m_read <= 1'b1;
          m_addr <= STATUS_ADDR;
        end

        S_POLL: begin
          state <= S_PWAIT;
          cnt   <= 32'd1;
`ifdef RNN_HOST_POLL_TIMEOUT_EN
          poll_cnt <= poll_cnt + 32'd1;
`endif
        end

        S_PWAIT: begin
          if (cnt >= RD_LAT) begin
            if (m_rdata[0]) begin
              state  <= S_FETCH;
              m_read <= 1'b1;
              m_addr <= RESULT_ADDR;
            end
`ifdef RNN_HOST_POLL_TIMEOUT_EN
            else if (poll_cnt >= TIMEOUT) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
`endif
            else if (POLL_GAP == 0) begin
              state  <= S_POLL;
              m_read <= 1'b1;
              m_addr <= STATUS_ADDR;
            end else begin
              state <= S_GAP;
              cnt   <= 32'd1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_GAP: begin
          if (cnt >= POLL_GAP) begin
            state  <= S_POLL;
            m_read <= 1'b1;
            m_addr <= STATUS_ADDR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_FETCH: begin
          state <= S_FWAIT;
          cnt   <= 32'd1;
        end

        S_FWAIT: begin
          // result_valid high means the result was captured last cycle;
          // this is the cycle that drops busy and returns to IDLE.
          if (result_valid) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt >= RD_LAT) begin
            result       <= m_rdata;
            result_valid <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rnn_host_master.sv
//============================================================================
// Module   : tb_rnn_host_master
// Purpose  : Self-checking bench for rnn_host_master. Expected bus cycles
//            and results are queued when stimulus is set up and popped as
//            the DUT issues strobes / result pulses. A small slave model
//            answers reads RD_LAT cycles after the strobe.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rnn_host_master;

  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned POLL_GAP = 4;
  localparam int unsigned TIMEOUT  = 3;
  localparam logic [31:0] CTRL = 32'h0000_1000;
  localparam logic [31:0] STAT = 32'h0000_1004;
  localparam logic [31:0] RES  = 32'h0000_1008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dst_base = '0;
  logic [15:0] word_count = '0;
  logic        busy;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 32'hBAD0_BAD0;
  logic [31:0] result;
  logic        result_valid;
  logic        error;

  always #5 clk = ~clk;

  rnn_host_master #(
    .CTRL_ADDR(CTRL), .STATUS_ADDR(STAT), .RESULT_ADDR(RES),
    .RD_LAT(RD_LAT), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dst_base(dst_base),
    .word_count(word_count), .busy(busy), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_read(m_read), .m_write(m_write),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .result(result),
    .result_valid(result_valid), .error(error)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_q[$];
  logic [31:0] res_q[$];
  logic [31:0] stream_q[$];
  logic [31:0] status_q[$];
  int          stat_cycles[$];
  logic        status_dflt = 1'b1;
  logic        gap_mode = 1'b0;
  logic [31:0] res_val = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int start_cyc = 0, rv_cyc = 0, idle_cyc = 0;
  int rv_count = 0, wr_seen = 0, sready_cycles = 0;
  bus_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus / result monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_ready) sready_cycles++;
      if (m_read || m_write) begin
        check("rw_exclusive", 32'(m_read & m_write), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_bus_op", m_addr, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("bus_dir", 32'(m_write), 32'(mon_e.wr));
          check("bus_addr", m_addr, mon_e.addr);
          if (mon_e.wr) check("bus_wdata", m_wdata, mon_e.data);
        end
        if (m_write) wr_seen++;
        if (m_read && m_addr == STAT) stat_cycles.push_back(cyc);
      end
      if (result_valid) begin
        rv_count++;
        rv_cyc = cyc;
        if (res_q.size() == 0) check("unexpected_result", result, 32'hFFFF_FFFF);
        else check("result", result, res_q.pop_front());
      end
    end
  end

  // Accelerator slave: read data valid during the cycle after the strobe
  logic [31:0] rd_addr;
  always begin
    @(negedge clk);
    if (rst_n && m_read) begin
      rd_addr = m_addr;
      @(posedge clk); #1;
      if (rd_addr == STAT) begin
        if (status_q.size() > 0) m_rdata = status_q.pop_front();
        else m_rdata = {31'd0, status_dflt};
      end else if (rd_addr == RES) begin
        m_rdata = res_val;
      end else begin
        m_rdata = 32'hDEAD_BEEE;
      end
      @(posedge clk); #1;
      m_rdata = 32'hBAD0_BAD0;
    end
  end

  // Stream source: handshake judged mid-cycle, next word presented after edge
  logic hs;
  always begin
    @(negedge clk);
    hs = s_valid && s_ready;
    @(posedge clk); #1;
    if (hs && stream_q.size() > 0) void'(stream_q.pop_front());
    if (stream_q.size() > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
      s_valid = 1'b1;
      s_data  = stream_q[0];
    end else begin
      s_valid = 1'b0;
    end
  end

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back({1'b0, a, 32'd0});
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] wc);
    @(negedge clk);
    dst_base = base; word_count = wc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    idle_cyc = cyc;
    check(tag, 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("results_drained", 32'(res_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {26'd0, busy, s_ready, m_read, m_write, result_valid, error}, 32'd0);
    check("zero_addr", m_addr, 32'd0);
    check("zero_wdata", m_wdata, 32'd0);
    check("zero_result", result, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_ctrl_zero");
    @(negedge clk) rst_n = 1'b1;

    // 1: three words back-to-back, status done on first poll
    stream_q.push_back(32'hA); stream_q.push_back(32'hB); stream_q.push_back(32'hC);
    exp_wr(32'h10, 32'hA); exp_wr(32'h11, 32'hB); exp_wr(32'h12, 32'hC);
    exp_wr(CTRL, 32'd1); exp_rd(STAT); exp_rd(RES);
    res_val = 32'h55; res_q.push_back(32'h55);
    rv_count = 0; sready_cycles = 0;
    do_start(32'h10, 16'd3);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_idle("t1_idle", 100);
    check("t1_latency", 32'(rv_cyc - start_cyc), 32'd9);   // N+6 with N=3
    check("t1_rv_pulses", 32'(rv_count), 32'd1);
    check("t1_busy_fall", 32'(idle_cyc - rv_cyc), 32'd1);
    check("t1_sready_cycles", 32'(sready_cycles), 32'd3);
    repeat (3) @(negedge clk);
    check("t1_result_held", result, 32'h55);

    // 2: zero words, control write comes first
    exp_wr(CTRL, 32'd1); exp_rd(STAT); exp_rd(RES);
    res_val = 32'h77; res_q.push_back(32'h77);
    rv_count = 0; sready_cycles = 0;
    do_start(32'h80, 16'd0);
    wait_idle("t2_idle", 100);
    check("t2_no_sready", 32'(sready_cycles), 32'd0);
    check("t2_rv_pulses", 32'(rv_count), 32'd1);

    // 3: status 0,0,1 -> three polls spaced by RD_LAT+POLL_GAP idle cycles
    stream_q.push_back(32'h1234);
    status_q.push_back(32'hFFFF_FFFE); status_q.push_back(32'h0000_0002);
    status_q.push_back(32'h0000_0001);
    exp_wr(32'h300, 32'h1234); exp_wr(CTRL, 32'd1);
    exp_rd(STAT); exp_rd(STAT); exp_rd(STAT); exp_rd(RES);
    res_val = 32'hCAFE; res_q.push_back(32'hCAFE);
    stat_cycles.delete();
    do_start(32'h300, 16'd1);
    wait_idle("t3_idle", 200);
    check("t3_poll_count", 32'(stat_cycles.size()), 32'd3);
    if (stat_cycles.size() == 3) begin
      check("t3_poll_spacing0", 32'(stat_cycles[1] - stat_cycles[0]), 32'd6);
      check("t3_poll_spacing1", 32'(stat_cycles[2] - stat_cycles[1]), 32'd6);
    end

    // 4: stray start during LOAD with a different base is ignored
    gap_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stream_q.push_back(32'h4000 + 32'(i));
      exp_wr(32'h200 + 32'(i), 32'h4000 + 32'(i));
    end
    exp_wr(CTRL, 32'd1); exp_rd(STAT); exp_rd(RES);
    res_val = 32'h0BAD_F00D; res_q.push_back(32'h0BAD_F00D);
    do_start(32'h200, 16'd4);
    @(negedge clk);
    dst_base = 32'h900; word_count = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_held", 32'(busy), 32'd1);
    wait_idle("t4_idle", 300);
    gap_mode = 1'b0;

    // 5: reset after two of five words loaded, then restart from idx 0
    for (int i = 0; i < 5; i++) begin
      stream_q.push_back(32'h5000 + 32'(i));
      exp_wr(32'h500 + 32'(i), 32'h5000 + 32'(i));
    end
    wr_seen = 0;
    do_start(32'h500, 16'd5);
    begin
      int n = 0;
      while (wr_seen < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_two_writes", 32'(wr_seen >= 2), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_reset_zero");
    exp_q.delete(); stream_q.delete(); status_q.delete();
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stream_q.push_back(32'h111); stream_q.push_back(32'h222);
    exp_wr(32'h40, 32'h111); exp_wr(32'h41, 32'h222);
    exp_wr(CTRL, 32'd1); exp_rd(STAT); exp_rd(RES);
    res_val = 32'h99; res_q.push_back(32'h99);
    do_start(32'h40, 16'd2);
    wait_idle("t5_idle", 100);

`ifdef RNN_HOST_POLL_TIMEOUT_EN
    // 6: status never done -> TIMEOUT polls, error, no result
    status_dflt = 1'b0;
    exp_wr(CTRL, 32'd1); exp_rd(STAT); exp_rd(STAT); exp_rd(STAT);
    rv_count = 0;
    do_start(32'h0, 16'd0);
    wait_idle("t6_idle", 200);
    check("t6_error_set", 32'(error), 32'd1);
    check("t6_no_result", 32'(rv_count), 32'd0);
    status_dflt = 1'b1;
    exp_wr(CTRL, 32'd1); exp_rd(STAT); exp_rd(RES);
    res_val = 32'h66; res_q.push_back(32'h66);
    do_start(32'h0, 16'd0);
    check("t6_error_cleared", 32'(error), 32'd0);
    wait_idle("t6b_idle", 100);
`else
    check("error_tied_low", 32'(error), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
